// File: rtl/cpu6502_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu6502_pkg
// Description : Shared constants for the 6502 core: processor status flag
//               bit positions and the push-only bits of the status image.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu6502_pkg;

    // Architectural flag positions inside P
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    // Bits that exist only in the stacked image, never in the register
    localparam int P_PUSH_ONE = 5;
    localparam int P_BRK      = 4;

    // Bits actually held by the status register
    localparam logic [7:0] P_STORED_MASK = 8'hCF;

endpackage
`default_nettype wire

// File: rtl/irq_mask_pipe.sv
`default_nettype none
// ============================================================================
// Module      : irq_mask_pipe
// Description : Shift register of interrupt-disable samples that advances only
//               on instruction boundaries. A set-all input raises every stage
//               at once so masking takes effect immediately, while unmasking
//               ripples through DEPTH boundaries.
//   i_clk      in   clock
//   i_reset    in   synchronous active-high reset (stages <= RESET_VAL)
//   i_commit   in   instruction boundary strobe, shifts the pipe
//   i_set_all  in   force every stage to 1
//   i_d        in   I value being written this cycle (post-update)
//   o_mask     out  last stage
// Revision    : 1.0 - initial release
// ============================================================================
module irq_mask_pipe #(
    parameter int DEPTH     = 1,
    parameter bit RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_commit,
    input  logic i_set_all,
    input  logic i_d,
    output logic o_mask
);

    logic [DEPTH-1:0] r_stages;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stages <= {DEPTH{RESET_VAL}};
        end else if (i_set_all) begin
            // Mask-on must not wait for instruction boundaries
            r_stages <= '1;
        end else if (i_commit) begin
            r_stages[0] <= i_d;
            for (int k = 1; k < DEPTH; k++) begin
                r_stages[k] <= r_stages[k-1];
            end
        end
    end

    assign o_mask = r_stages[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/processor_status_unit.sv
`default_nettype none
// ============================================================================
// Module      : processor_status_unit
// Description : 6502 processor status register (C Z I D V N) with per-flag
//               prioritised load sources, stack-push image generation and a
//               boundary-delayed interrupt mask.
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_db                      internal data bus
//   i_db_p                    load all flags from i_db (PLP/RTI)
//   i_ir5, i_acr, i_avr       instruction bit 5, ALU carry, ALU overflow
//   i_*_c/_z/_d/_i/_v/_n      per-flag load selects
//   i_brk                     B bit for the push image
//   i_commit                  instruction boundary strobe
//   o_p                       flags, bits 5/4 read 0
//   o_p_push                  o_p with bit5=1, bit4=i_brk
//   o_irq_mask                delayed I for IRQ gating
//   o_decimal                 D gated by DECIMAL_EN
// Revision    : 1.0 - initial release
// ============================================================================
module processor_status_unit
    import cpu6502_pkg::*;
#(
    parameter int         IMASK_DELAY = 1,
    parameter bit         DECIMAL_EN  = 1'b0,
    parameter logic [7:0] RESET_P     = 8'h04
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_db,
    input  logic       i_db_p,
    input  logic       i_ir5,
    input  logic       i_acr,
    input  logic       i_avr,
    input  logic       i_db0_c,
    input  logic       i_ir5_c,
    input  logic       i_acr_c,
    input  logic       i_db1_z,
    input  logic       i_dbz_z,
    input  logic       i_db3_d,
    input  logic       i_ir5_d,
    input  logic       i_ir5_i,
    input  logic       i_1_i,
    input  logic       i_db6_v,
    input  logic       i_avr_v,
    input  logic       i_0_v,
    input  logic       i_db7_n,
    input  logic       i_brk,
    input  logic       i_commit,
    output logic [7:0] o_p,
    output logic [7:0] o_p_push,
    output logic       o_irq_mask,
    output logic       o_decimal
);

    logic [7:0] r_p;
    logic [7:0] w_p_next;

    // Each flag picks at most one source; unselected flags hold
    always_comb begin
        w_p_next = r_p;

        if (i_acr_c)      w_p_next[FLAG_C] = i_acr;
        else if (i_ir5_c) w_p_next[FLAG_C] = i_ir5;
        else if (i_db0_c) w_p_next[FLAG_C] = i_db[0];
        else if (i_db_p)  w_p_next[FLAG_C] = i_db[FLAG_C];

        if (i_dbz_z)      w_p_next[FLAG_Z] = (i_db == 8'h00);
        else if (i_db1_z) w_p_next[FLAG_Z] = i_db[1];
        else if (i_db_p)  w_p_next[FLAG_Z] = i_db[FLAG_Z];

        if (i_ir5_d)      w_p_next[FLAG_D] = i_ir5;
        else if (i_db3_d) w_p_next[FLAG_D] = i_db[3];
        else if (i_db_p)  w_p_next[FLAG_D] = i_db[FLAG_D];

        if (i_1_i)        w_p_next[FLAG_I] = 1'b1;
        else if (i_ir5_i) w_p_next[FLAG_I] = i_ir5;
        else if (i_db_p)  w_p_next[FLAG_I] = i_db[FLAG_I];

        if (i_0_v)        w_p_next[FLAG_V] = 1'b0;
        else if (i_avr_v) w_p_next[FLAG_V] = i_avr;
        else if (i_db6_v) w_p_next[FLAG_V] = i_db[6];
        else if (i_db_p)  w_p_next[FLAG_V] = i_db[FLAG_V];

        if (i_db7_n)      w_p_next[FLAG_N] = i_db[7];
        else if (i_db_p)  w_p_next[FLAG_N] = i_db[FLAG_N];

        // B and bit 5 have no storage; they only appear on the stack image
        w_p_next[P_PUSH_ONE] = 1'b0;
        w_p_next[P_BRK]      = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_p <= RESET_P & P_STORED_MASK;
        end else begin
            r_p <= w_p_next;
        end
    end

    assign o_p = r_p;

    always_comb begin
        o_p_push             = r_p;
        o_p_push[P_PUSH_ONE] = 1'b1;
        o_p_push[P_BRK]      = i_brk;
    end

    assign o_decimal = DECIMAL_EN & r_p[FLAG_D];

    generate
        if (IMASK_DELAY == 0) begin : g_mask_direct
            assign o_irq_mask = r_p[FLAG_I];
        end else begin : g_mask_pipe
            irq_mask_pipe #(
                .DEPTH     (IMASK_DELAY),
                .RESET_VAL (RESET_P[FLAG_I])
            ) u_irq_mask_pipe (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .i_commit  (i_commit),
                .i_set_all (i_1_i),
                .i_d       (w_p_next[FLAG_I]),
                .o_mask    (o_irq_mask)
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_processor_status_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_processor_status_unit
// Description : Self-checking bench for processor_status_unit. Four instances
//               with different delay / decimal / reset parameters share one
//               input stream and are compared against a flag-rule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_processor_status_unit;

    localparam int         NI = 4;
    localparam int         DLY [NI] = '{1, 2, 0, 3};
    localparam bit         DEN [NI] = '{1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [7:0] RP  [NI] = '{8'h04, 8'h04, 8'h04, 8'hC9};

    logic       clk = 1'b0;
    logic       reset, db_p, ir5, acr, avr;
    logic       db0_c, ir5_c, acr_c, db1_z, dbz_z, db3_d, ir5_d;
    logic       ir5_i, one_i, db6_v, avr_v, zero_v, db7_n, brk, commit;
    logic [7:0] db;

    logic [7:0] p    [NI];
    logic [7:0] push [NI];
    logic       mask [NI];
    logic       dec  [NI];

    int compared   = 0;
    int mismatched = 0;

    // Model state: flag byte and the history of I samples taken at commits
    logic [7:0] m_p [NI];
    logic       m_h [NI][3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        processor_status_unit #(
            .IMASK_DELAY (DLY[g]),
            .DECIMAL_EN  (DEN[g]),
            .RESET_P     (RP[g])
        ) u_dut (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_db       (db),
            .i_db_p     (db_p),
            .i_ir5      (ir5),
            .i_acr      (acr),
            .i_avr      (avr),
            .i_db0_c    (db0_c),
            .i_ir5_c    (ir5_c),
            .i_acr_c    (acr_c),
            .i_db1_z    (db1_z),
            .i_dbz_z    (dbz_z),
            .i_db3_d    (db3_d),
            .i_ir5_d    (ir5_d),
            .i_ir5_i    (ir5_i),
            .i_1_i      (one_i),
            .i_db6_v    (db6_v),
            .i_avr_v    (avr_v),
            .i_0_v      (zero_v),
            .i_db7_n    (db7_n),
            .i_brk      (brk),
            .i_commit   (commit),
            .o_p        (p[g]),
            .o_p_push   (push[g]),
            .o_irq_mask (mask[g]),
            .o_decimal  (dec[g])
        );
    end

    task automatic check(input string tag, input int k,
                         input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s[%0d] observed=%h expected=%h at %0t", tag, k, obs, exp, $time);
            $error("check %s[%0d] differs", tag, k);
        end
    endtask

    task automatic clear_inputs();
        reset = 0; db_p = 0; ir5 = 0; acr = 0; avr = 0; db = 8'h00;
        db0_c = 0; ir5_c = 0; acr_c = 0; db1_z = 0; dbz_z = 0;
        db3_d = 0; ir5_d = 0; ir5_i = 0; one_i = 0; db6_v = 0;
        avr_v = 0; zero_v = 0; db7_n = 0; commit = 0;
    endtask

    // Bit value chosen for one flag: first asserted source in priority order
    function automatic logic pick(input logic cur, input logic [3:0] sel,
                                  input logic [3:0] val);
        for (int s = 0; s < 4; s++)
            if (sel[s]) return val[s];
        return cur;
    endfunction

    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                m_p[k] = RP[k] & 8'hCF;
                for (int s = 0; s < 3; s++) m_h[k][s] = RP[k][2];
            end else begin
                logic [7:0] n;
                n    = 8'h00;
                n[0] = pick(m_p[k][0], {db_p, db0_c, ir5_c, acr_c}, {db[0], db[0], ir5, acr});
                n[1] = pick(m_p[k][1], {1'b0, db_p, db1_z, dbz_z}, {1'b0, db[1], db[1], db == 8'h00});
                n[2] = pick(m_p[k][2], {1'b0, db_p, ir5_i, one_i}, {1'b0, db[2], ir5, 1'b1});
                n[3] = pick(m_p[k][3], {1'b0, db_p, db3_d, ir5_d}, {1'b0, db[3], db[3], ir5});
                n[6] = pick(m_p[k][6], {db_p, db6_v, avr_v, zero_v}, {db[6], db[6], avr, 1'b0});
                n[7] = pick(m_p[k][7], {2'b00, db_p, db7_n}, {2'b00, db[7], db[7]});
                m_p[k] = n;
                if (one_i) begin
                    for (int s = 0; s < 3; s++) m_h[k][s] = 1'b1;
                end else if (commit) begin
                    m_h[k][2] = m_h[k][1];
                    m_h[k][1] = m_h[k][0];
                    m_h[k][0] = n[2];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            logic exp_mask;
            exp_mask = (DLY[k] == 0) ? m_p[k][2] : m_h[k][DLY[k]-1];
            check("p", k, p[k], m_p[k]);
            check("push", k, push[k], {m_p[k][7:6], 1'b1, brk, m_p[k][3:0]});
            check("irq_mask", k, {7'd0, mask[k]}, {7'd0, exp_mask});
            check("decimal", k, {7'd0, dec[k]}, {7'd0, DEN[k] & m_p[k][3]});
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        clear_inputs();
        brk = 0;
        for (int k = 0; k < NI; k++) begin
            m_p[k] = 8'h00;
            for (int s = 0; s < 3; s++) m_h[k][s] = 1'b0;
        end

        // Reset state and push image for both B values
        reset = 1; tick();
        check("reset_p", 0, p[0], 8'h04);
        check("reset_mask", 0, {7'd0, mask[0]}, 8'h01);
        check("push_irq", 0, push[0], 8'h24);
        check("reset_p_alt", 3, p[3], 8'hC9);
        brk = 1; #1;
        check_all();
        check("push_brk", 0, push[0], 8'h34);
        clear_inputs();

        // Z from zero-detect, then N from bus bit 7 with Z held
        db = 8'h00; dbz_z = 1; tick(); clear_inputs();
        check("z_set", 0, p[0], 8'h06);
        db = 8'h80; db7_n = 1; tick(); clear_inputs();
        check("n_set", 0, p[0], 8'h86);

        // PLP of all ones: bits 5/4 must stay clear
        db = 8'hFF; db_p = 1; tick(); clear_inputs();
        check("plp_ff", 0, p[0], 8'hCF);

        // ALU carry beats instruction bit 5
        acr_c = 1; acr = 0; ir5_c = 1; ir5 = 1; tick(); clear_inputs();
        check("acr_prio", 0, p[0], 8'hCE);

        // CLI: flag drops now, mask waits for a boundary
        ir5_i = 1; ir5 = 0; tick(); clear_inputs();
        check("cli_flag", 0, p[0], 8'hCA);
        check("cli_mask_hold", 0, {7'd0, mask[0]}, 8'h01);
        tick();
        commit = 1; tick(); clear_inputs();
        check("cli_mask_d1", 0, {7'd0, mask[0]}, 8'h00);
        check("cli_mask_d2_hold", 1, {7'd0, mask[1]}, 8'h01);
        commit = 1; tick(); clear_inputs();
        check("cli_mask_d2", 1, {7'd0, mask[1]}, 8'h00);

        // Interrupt entry masks immediately
        one_i = 1; tick(); clear_inputs();
        check("sei_now", 0, {7'd0, mask[0]}, 8'h01);

        // PLP with I=0, one commit, then reset mid-pipeline
        db = 8'h00; db_p = 1; tick(); clear_inputs();
        commit = 1; tick(); clear_inputs();
        check("plp_d2_hold", 1, {7'd0, mask[1]}, 8'h01);
        reset = 1; tick(); clear_inputs();
        check("rst_mid_mask", 1, {7'd0, mask[1]}, 8'h01);
        check("rst_mid_p", 1, p[1], 8'h04);

        // SED: stored everywhere, visible only when decimal is enabled
        ir5_d = 1; ir5 = 1; tick(); clear_inputs();
        check("sed_flag", 0, p[0], 8'h0C);
        check("sed_gated", 0, {7'd0, dec[0]}, 8'h00);
        check("sed_pass", 1, {7'd0, dec[1]}, 8'h01);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 49) == 0);
            db     = 8'($urandom);
            ir5    = 1'($urandom);
            acr    = 1'($urandom);
            avr    = 1'($urandom);
            brk    = 1'($urandom);
            db_p   = ($urandom_range(0, 5) == 0);
            db0_c  = ($urandom_range(0, 4) == 0);
            ir5_c  = ($urandom_range(0, 4) == 0);
            acr_c  = ($urandom_range(0, 4) == 0);
            db1_z  = ($urandom_range(0, 4) == 0);
            dbz_z  = ($urandom_range(0, 4) == 0);
            db3_d  = ($urandom_range(0, 4) == 0);
            ir5_d  = ($urandom_range(0, 4) == 0);
            ir5_i  = ($urandom_range(0, 3) == 0);
            one_i  = ($urandom_range(0, 11) == 0);
            db6_v  = ($urandom_range(0, 4) == 0);
            avr_v  = ($urandom_range(0, 4) == 0);
            zero_v = ($urandom_range(0, 6) == 0);
            db7_n  = ($urandom_range(0, 4) == 0);
            commit = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
